// File: rtl/bram_top.sv
// True dual-port block RAM, one clock, registered write-first read ports.
// Port A wins when both ports write the same address on the same edge.
module bram_top #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena_a,
   input  logic                  wea_a,
   input  logic [ADDR_WIDTH-1:0] addra_a,
   input  logic [DATA_WIDTH-1:0] dina_a,
   output logic [DATA_WIDTH-1:0] douta_a,
   input  logic                  enb_b,
   input  logic                  web_b,
   input  logic [ADDR_WIDTH-1:0] addrb_b,
   input  logic [DATA_WIDTH-1:0] dinb_b,
   output logic [DATA_WIDTH-1:0] doutb_b
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Power-up contents are zero; reset never touches the array.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic wr_a;
   logic wr_b;
   logic same_addr;

   assign wr_a      = ena_a & wea_a;
   assign wr_b      = enb_b & web_b;
   assign same_addr = (addra_a == addrb_b);

   always_ff @(posedge clk) begin
      if (wr_a)
         mem[addra_a] <= dina_a;
      if (wr_b && !(wr_a && same_addr))
         mem[addrb_b] <= dinb_b;
   end

   // Array reads see pre-edge contents, so a cross-port reader gets old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         douta_a <= '0;
      else if (ena_a)
         douta_a <= wea_a ? dina_a : mem[addra_a];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         doutb_b <= '0;
      else if (enb_b)
         doutb_b <= web_b ? dinb_b : mem[addrb_b];
   end

endmodule

// File: tb/tb_bram_top.sv
// Directed self-checking bench for bram_top with hand-computed expectations.
module tb_bram_top;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena_a, wea_a, enb_b, web_b;
   logic [9:0] addra_a, addrb_b;
   logic [7:0] dina_a, dinb_b;
   logic [7:0] douta_a, doutb_b;

   int checks   = 0;
   int failures = 0;

   bram_top #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ena_a(ena_a), .wea_a(wea_a), .addra_a(addra_a), .dina_a(dina_a), .douta_a(douta_a),
      .enb_b(enb_b), .web_b(web_b), .addrb_b(addrb_b), .dinb_b(dinb_b), .doutb_b(doutb_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic port_a(input logic en, input logic we, input logic [9:0] ad, input logic [7:0] d);
      ena_a = en; wea_a = we; addra_a = ad; dina_a = d;
   endtask

   task automatic port_b(input logic en, input logic we, input logic [9:0] ad, input logic [7:0] d);
      enb_b = en; web_b = we; addrb_b = ad; dinb_b = d;
   endtask

   initial begin
      rst_n = 1'b0;
      port_a(0, 0, 10'h000, 8'h00);
      port_b(0, 0, 10'h000, 8'h00);
      repeat (2) tick();
      chk("reset_a", douta_a, 8'h00);
      chk("reset_b", doutb_b, 8'h00);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("post_reset_idle_a", douta_a, 8'h00);
      chk("post_reset_idle_b", doutb_b, 8'h00);

      // Port A writes on consecutive edges; write-first on douta_a.
      port_a(1, 1, 10'h010, 8'hAA); tick();
      chk("wr_first_a_010", douta_a, 8'hAA);
      port_a(1, 1, 10'h025, 8'hBB); tick();
      port_a(1, 1, 10'h0FF, 8'hCC); tick();
      chk("wr_first_a_0ff", douta_a, 8'hCC);
      port_a(0, 0, 10'h000, 8'h00);

      // Port B reads them back, one per cycle.
      port_b(1, 0, 10'h010, 8'h00); tick();
      chk("rd_b_010", doutb_b, 8'hAA);
      port_b(1, 0, 10'h025, 8'h00); tick();
      chk("rd_b_025", doutb_b, 8'hBB);
      port_b(1, 0, 10'h0FF, 8'h00); tick();
      chk("rd_b_0ff", doutb_b, 8'hCC);

      // Disabled ports hold.
      port_b(0, 0, 10'h010, 8'h77);
      repeat (2) tick();
      chk("hold_b", doutb_b, 8'hCC);
      chk("hold_a", douta_a, 8'hCC);

      // Async reset between edges.
      rst_n = 1'b0;
      #2;
      chk("async_rst_b", doutb_b, 8'h00);
      chk("async_rst_a", douta_a, 8'h00);
      rst_n = 1'b1;
      tick();
      chk("rst_release_hold_b", doutb_b, 8'h00);
      port_b(1, 0, 10'h025, 8'h00); tick();
      chk("retained_025", doutb_b, 8'hBB);

      // Port B write-first at the top address, read back on A.
      port_b(1, 1, 10'h3FF, 8'h5A); tick();
      chk("wr_first_b_3ff", doutb_b, 8'h5A);
      port_b(0, 0, 10'h000, 8'h00);
      port_a(1, 0, 10'h3FF, 8'h00); tick();
      chk("rd_a_3ff", douta_a, 8'h5A);

      // Cross-port collision: B reads old data, then new.
      port_a(1, 1, 10'h010, 8'h11);
      port_b(1, 0, 10'h010, 8'h00); tick();
      chk("coll_b_old", doutb_b, 8'hAA);
      chk("coll_a_wf", douta_a, 8'h11);
      port_a(0, 0, 10'h000, 8'h00); tick();
      chk("coll_b_new", doutb_b, 8'h11);

      // Both write same address: A's data stored, each sees its own din.
      port_a(1, 1, 10'h020, 8'h01);
      port_b(1, 1, 10'h020, 8'h02); tick();
      chk("dual_wr_a", douta_a, 8'h01);
      chk("dual_wr_b", doutb_b, 8'h02);
      port_a(1, 0, 10'h020, 8'hFF);
      port_b(1, 0, 10'h020, 8'hEE); tick();
      chk("dual_rd_a", douta_a, 8'h01);
      chk("dual_rd_b", doutb_b, 8'h01);

      // Unwritten location reads zero; din ignored on a read.
      port_a(1, 0, 10'h100, 8'h99);
      port_b(1, 0, 10'h000, 8'h33); tick();
      chk("unwritten_100", douta_a, 8'h00);
      chk("unwritten_000", doutb_b, 8'h00);
      port_a(1, 0, 10'h025, 8'hFF); tick();
      chk("rd_ignores_din", douta_a, 8'hBB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
